// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
// restoring shift-subtract divide on operand magnitudes, one step per clock,
// with a one-cycle writeback pulse that drives the register file write port.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;   // final result must be negated
  logic              byp_q;   // special-case result parked in acc_q low half
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   opb_q;   // multiplicand for mul, divisor magnitude for div
  logic [2*XLEN-1:0] acc_q;   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}

  // Request decode: operand signedness, magnitudes and special cases.
  logic            is_div, a_signed, b_signed, sa, sb;
  logic            div_zero, div_ovf, bypass, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, byp_res;

  // Decode the incoming request and precompute bypass results.
  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
    b_signed = is_div ? ~funct3[0] : (funct3 == 3'b001);
    sa       = a_signed & rs1_val[XLEN-1];
    sb       = b_signed & rs2_val[XLEN-1];
    a_mag    = sa ? -rs1_val : rs1_val;
    b_mag    = sb ? -rs2_val : rs2_val;
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_val == MinInt) && (rs2_val == '1);
    bypass   = div_zero | div_ovf;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
    if (div_zero) begin
      byp_res = funct3[1] ? rs1_val : '1;
    end else begin
      byp_res = funct3[1] ? '0 : MinInt;
    end
  end

  // One radix-2 step and final sign fix-up.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, quo, rem, calc_res, final_res;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod;

  // Compute the next accumulator value and the result it would produce.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
    div_sub   = div_shift[XLEN-1:0] - opb_q;
    if (op_q[2]) begin
      acc_next = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                   calc_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011:   calc_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:           calc_res = quo;
      default:                  calc_res = rem;
    endcase
    final_res = byp_q ? acc_q[XLEN-1:0] : calc_res;
  end

  // Control FSM with registered outputs and datapath state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      byp_q   <= 1'b0;
      cnt_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      rd_out  <= '0;
      result  <= '0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StCalc;
            op_q    <= funct3;
            rd_q    <= rd_in;
            neg_q   <= neg_in;
            opb_q   <= b_mag;
            byp_q   <= bypass;
            if (bypass) begin
              // Single pass through CALC with counter 0; busy stays low.
              cnt_q <= '0;
              acc_q <= {{XLEN{1'b0}}, byp_res};
              busy  <= 1'b0;
            end else begin
              cnt_q <= CW'(ITER - 1);
              acc_q <= {{XLEN{1'b0}}, a_mag};
              busy  <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StCalc: begin
          if (!byp_q) begin
            acc_q <= acc_next;
          end
          if (cnt_q == '0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            wb_en   <= (rd_q != 5'd0);
            rd_out  <= rd_q;
            result  <= final_res;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a scoreboard of expected writebacks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .wb_en   (wb_en),
    .rd_out  (rd_out),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          ntests = 0;
  int          nfail = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a request so it is accepted at the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expr, input int lat,
                       input bit push);
    @(negedge clk);
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    if (push) sb.push_back(exp_t'{expr, rd, (rd != 5'd0), lat});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from acceptance until done, then check against the scoreboard head.
  task automatic wait_done(input string tag, input int n0, input int b0);
    exp_t e;
    int   n = n0;
    int   bc = b0;
    chk({tag, "_hold_res"}, result, last_res);
    chk({tag, "_hold_rd"}, rd_out, last_rd);
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, n, e.lat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_result"}, result, e.res);
    chk({tag, "_rd_out"}, rd_out, e.rd);
    chk({tag, "_wb_en"}, wb_en, e.wb);
    chk({tag, "_busy_cycles"}, bc, (e.lat == 32) ? 32 : 0);
    last_res = e.res;
    last_rd  = e.rd;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expr,
                        input int lat);
    issue(f3, a, b, rd, expr, lat, 1'b1);
    wait_done(tag, 0, 0);
  endtask

  initial begin
    int          seen;
    logic [2:0]  f3;
    logic [31:0] a, b, expr;
    logic [63:0] p;

    // Power-on reset.
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd_out", rd_out, 5'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Multiplies (first from IDLE, then back-to-back from DONE).
    run_op("mul_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 32);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 32);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 32);

    // Divides.
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 32);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 32);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 32);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 32);

    // Special cases bypass the iterative path.
    repeat (3) @(posedge clk);
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", 3'b110, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run_op("divu_by0", 3'b101, 32'd9, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 1);

    // rd = 0 completes but must not write back.
    run_op("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 32);

    // start with new operands mid-CALC is ignored.
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 32, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start   = 1'b1;
    funct3  = 3'b000;
    rs1_val = 32'd9;
    rs2_val = 32'd9;
    rd_in   = 5'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_mid", 6, 6);
    repeat (40) @(posedge clk);
    #1;
    chk("ignore_no_second_done", done, 1'b0);

    // Random unsigned ops against a reference model.
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      b = $urandom();
      if (b == 32'd0) b = 32'd1;
      f3 = (i % 4 == 0) ? 3'b000 : (i % 4 == 1) ? 3'b011 : (i % 4 == 2) ? 3'b101 : 3'b111;
      p = {32'h0, a} * {32'h0, b};
      case (f3)
        3'b000:  expr = p[31:0];
        3'b011:  expr = p[63:32];
        3'b101:  expr = a / b;
        default: expr = a % b;
      endcase
      run_op("rand", f3, a, b, 5'(i + 20), expr, 32);
    end

    // Asynchronous reset at step 10 of a divide.
    issue(3'b101, 32'd1000, 32'd3, 5'd4, 32'd0, 32, 1'b0);
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_wb_en", wb_en, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_rd_out", rd_out, 5'h0);
    @(negedge clk);
    resetn = 1'b1;
    last_res = '0;
    last_rd  = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || wb_en === 1'b1) seen++;
    end
    chk("arst_no_done", seen, 0);
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, 32);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
